// File: rtl/speed_round_ctrl.sv
// speed_round_ctrl
//   Sequences one speed round for a push-counter game. A start request clears the push
//   counters, shows a countdown, opens the push window for a fixed number of ticks,
//   waits for the counter comparison to settle, and latches the winner. The winner is
//   held for a display period, and the counters are cleared again on exit.
//
// Ports
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-high reset
//   i_tick         one-clk timebase enable pulse
//   i_start        round request (level, honoured only in IDLE)
//   i_abort        synchronous cancel of the current round
//   i_speed_right  push-counter result: right count greater
//   i_speed_tie    push-counter result: counts equal
//   o_speed_round  push window open
//   o_speed_exit   one-clk pulse clearing the push counters
//   o_busy         high in every state except IDLE
//   o_cd_digit     countdown value, 0 outside COUNTDOWN
//   o_result_valid one-clk pulse coinciding with a winner update
//   o_winner       00 none, 01 left, 10 right, 11 tie
module speed_round_ctrl #(
   parameter int unsigned CD_STEPS      = 3,
   parameter int unsigned STEP_TICKS    = 1000,
   parameter int unsigned ROUND_TICKS   = 5000,
   parameter int unsigned SETTLE_CYCLES = 6,
   parameter int unsigned RESULT_TICKS  = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic       i_speed_right,
   input  logic       i_speed_tie,
   output logic       o_speed_round,
   output logic       o_speed_exit,
   output logic       o_busy,
   output logic [3:0] o_cd_digit,
   output logic       o_result_valid,
   output logic [1:0] o_winner
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, COUNTDOWN, ACTIVE, SETTLE, JUDGE, HOLD, EXIT
   } state_t;

   // Counters hold "events seen so far", so the last event matches the value minus one.
   localparam logic [15:0] STEP_LAST   = 16'(STEP_TICKS - 1);
   localparam logic [15:0] ROUND_LAST  = 16'(ROUND_TICKS - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] RESULT_LAST = 16'(RESULT_TICKS - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_speed_round;
   logic        r_speed_exit;
   logic        r_busy;
   logic [3:0]  r_cd_digit;
   logic        r_result_valid;
   logic [1:0]  r_winner;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_cnt          <= 16'd0;
         r_speed_round  <= 1'b0;
         r_speed_exit   <= 1'b0;
         r_busy         <= 1'b0;
         r_cd_digit     <= 4'd0;
         r_result_valid <= 1'b0;
         r_winner       <= 2'b00;
      end else begin
         r_speed_exit   <= 1'b0;
         r_result_valid <= 1'b0;
         if (r_state != IDLE && i_abort) begin
            // Abort while already exiting finishes the exit so the clear pulse stays single.
            if (r_state == EXIT) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end else begin
               r_state      <= EXIT;
               r_speed_exit <= 1'b1;
            end
            r_cnt         <= 16'd0;
            r_speed_round <= 1'b0;
            r_cd_digit    <= 4'd0;
            r_winner      <= 2'b00;
         end else begin
            case (r_state)
               IDLE: begin
                  if (i_start) begin
                     r_state      <= CLEAR;
                     r_speed_exit <= 1'b1;
                     r_busy       <= 1'b1;
                     r_cnt        <= 16'd0;
                  end
               end
               CLEAR: begin
                  r_state    <= COUNTDOWN;
                  r_cd_digit <= 4'(CD_STEPS);
                  r_cnt      <= 16'd0;
               end
               COUNTDOWN: begin
                  if (i_tick) begin
                     if (r_cnt == STEP_LAST) begin
                        r_cnt <= 16'd0;
                        if (r_cd_digit == 4'd1) begin
                           r_state       <= ACTIVE;
                           r_cd_digit    <= 4'd0;
                           r_speed_round <= 1'b1;
                        end else begin
                           r_cd_digit <= r_cd_digit - 4'd1;
                        end
                     end else begin
                        r_cnt <= r_cnt + 16'd1;
                     end
                  end
               end
               ACTIVE: begin
                  if (i_tick) begin
                     if (r_cnt == ROUND_LAST) begin
                        r_state       <= SETTLE;
                        r_cnt         <= 16'd0;
                        r_speed_round <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + 16'd1;
                     end
                  end
               end
               SETTLE: begin
                  // Counts clk cycles, not ticks: gives the push counters time to settle.
                  if (r_cnt == SETTLE_LAST) begin
                     r_state <= JUDGE;
                     r_cnt   <= 16'd0;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
               JUDGE: begin
                  if (i_speed_tie) begin
                     r_winner <= 2'b11;
                  end else if (i_speed_right) begin
                     r_winner <= 2'b10;
                  end else begin
                     r_winner <= 2'b01;
                  end
                  r_result_valid <= 1'b1;
                  r_state        <= HOLD;
                  r_cnt          <= 16'd0;
               end
               HOLD: begin
                  if (i_tick) begin
                     if (r_cnt == RESULT_LAST) begin
                        r_state      <= EXIT;
                        r_cnt        <= 16'd0;
                        r_speed_exit <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt + 16'd1;
                     end
                  end
               end
               EXIT: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= 16'd0;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= 16'd0;
               end
            endcase
         end
      end
   end

   assign o_speed_round  = r_speed_round;
   assign o_speed_exit   = r_speed_exit;
   assign o_busy         = r_busy;
   assign o_cd_digit     = r_cd_digit;
   assign o_result_valid = r_result_valid;
   assign o_winner       = r_winner;

endmodule

// File: tb/tb_speed_round_ctrl.sv
// tb_speed_round_ctrl
//   Directed bench for speed_round_ctrl with short timing parameters. Expected winners and
//   countdown digits are queued when a round is started and consumed by a monitor as the
//   DUT produces them; per-round event counts are checked once the round has finished.
module tb_speed_round_ctrl;

   localparam int unsigned CD_STEPS      = 3;
   localparam int unsigned STEP_TICKS    = 2;
   localparam int unsigned ROUND_TICKS   = 4;
   localparam int unsigned SETTLE_CYCLES = 6;
   localparam int unsigned RESULT_TICKS  = 2;
   localparam int          TIMEOUT       = 1000;

   logic       clk;
   logic       rst;
   logic       i_tick;
   logic       i_start;
   logic       i_abort;
   logic       i_speed_right;
   logic       i_speed_tie;
   logic       o_speed_round;
   logic       o_speed_exit;
   logic       o_busy;
   logic [3:0] o_cd_digit;
   logic       o_result_valid;
   logic [1:0] o_winner;

   int checks   = 0;
   int failures = 0;

   logic [1:0] exp_win_q[$];
   logic [3:0] exp_cd_q[$];

   // Monitor statistics, cleared by the stimulus at the start of each scenario.
   int exit_pulses = 0;
   int exit_cycles = 0;
   int rv_count    = 0;
   int round_ticks = 0;
   int settle_gap  = -1;
   int fall_cyc    = 0;
   int cyc         = 0;

   speed_round_ctrl #(
      .CD_STEPS     (CD_STEPS),
      .STEP_TICKS   (STEP_TICKS),
      .ROUND_TICKS  (ROUND_TICKS),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .RESULT_TICKS (RESULT_TICKS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_tick        (i_tick),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_speed_right (i_speed_right),
      .i_speed_tie   (i_speed_tie),
      .o_speed_round (o_speed_round),
      .o_speed_exit  (o_speed_exit),
      .o_busy        (o_busy),
      .o_cd_digit    (o_cd_digit),
      .o_result_valid(o_result_valid),
      .o_winner      (o_winner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tick every 4 clk, driven just after the rising edge.
   initial begin
      int phase;
      phase  = 0;
      i_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         phase  = (phase + 1) % 4;
         i_tick = (phase == 0);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor sampling on the falling edge.
   initial begin
      logic       prev_exit;
      logic       prev_round;
      logic [3:0] prev_cd;
      prev_exit  = 1'b0;
      prev_round = 1'b0;
      prev_cd    = 4'd0;
      forever begin
         @(negedge clk);
         if (o_speed_exit === 1'b1) begin
            exit_cycles++;
            if (!prev_exit) exit_pulses++;
         end
         prev_exit = o_speed_exit;
         if (o_speed_round === 1'b1 && i_tick === 1'b1) round_ticks++;
         if (prev_round && o_speed_round === 1'b0) fall_cyc = cyc;
         prev_round = o_speed_round;
         if (o_result_valid === 1'b1) begin
            rv_count++;
            settle_gap = cyc - fall_cyc;
            if (exp_win_q.size() == 0) begin
               check("unexpected_result", 32'(o_winner), 32'hffff_ffff);
            end else begin
               check("winner_scoreboard", 32'(o_winner), 32'(exp_win_q.pop_front()));
            end
         end
         if (o_cd_digit !== prev_cd && o_cd_digit !== 4'd0) begin
            if (exp_cd_q.size() == 0) begin
               check("unexpected_cd_digit", 32'(o_cd_digit), 32'hffff_ffff);
            end else begin
               check("cd_digit_scoreboard", 32'(o_cd_digit), 32'(exp_cd_q.pop_front()));
            end
         end
         prev_cd = o_cd_digit;
         cyc++;
      end
   end

   task automatic clear_stats();
      exit_pulses = 0;
      exit_cycles = 0;
      rv_count    = 0;
      round_ticks = 0;
      settle_gap  = -1;
   endtask

   task automatic push_countdown();
      exp_cd_q.push_back(4'd3);
      exp_cd_q.push_back(4'd2);
      exp_cd_q.push_back(4'd1);
   endtask

   task automatic wait_busy_low(input string tag);
      int n = 0;
      while (o_busy !== 1'b0 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_busy_low_timeout"}, 32'(n < TIMEOUT), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_speed_round"}, 32'(o_speed_round), 32'd0);
      check({tag, "_speed_exit"}, 32'(o_speed_exit), 32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_cd_digit"}, 32'(o_cd_digit), 32'd0);
      check({tag, "_result_valid"}, 32'(o_result_valid), 32'd0);
      check({tag, "_winner"}, 32'(o_winner), 32'd0);
   endtask

   // Drives start for one cycle and checks the CLEAR cycle that follows.
   task automatic pulse_start(input string tag);
      @(posedge clk);
      #1 i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      @(negedge clk);
      check({tag, "_clear_exit"}, 32'(o_speed_exit), 32'd1);
      check({tag, "_clear_busy"}, 32'(o_busy), 32'd1);
   endtask

   task automatic run_round(input logic right, input logic tie, input logic [1:0] exp_w,
                            input string tag);
      i_speed_right = right;
      i_speed_tie   = tie;
      exp_win_q.push_back(exp_w);
      push_countdown();
      clear_stats();
      pulse_start(tag);
      wait_busy_low(tag);
      check({tag, "_exit_pulses"}, 32'(exit_pulses), 32'd2);
      check({tag, "_exit_cycles"}, 32'(exit_cycles), 32'd2);
      check({tag, "_result_valid_count"}, 32'(rv_count), 32'd1);
      check({tag, "_round_ticks"}, 32'(round_ticks), 32'(ROUND_TICKS));
      // SETTLE_CYCLES in SETTLE plus the JUDGE cycle before result_valid.
      check({tag, "_settle_gap"}, 32'(settle_gap), 32'(SETTLE_CYCLES + 1));
      check({tag, "_winner_retained"}, 32'(o_winner), 32'(exp_w));
      check({tag, "_cd_queue_empty"}, 32'(exp_cd_q.size()), 32'd0);
      check({tag, "_win_queue_empty"}, 32'(exp_win_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      int saved_exits;
      rst           = 1'b1;
      i_start       = 1'b0;
      i_abort       = 1'b0;
      i_speed_right = 1'b0;
      i_speed_tie   = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(o_busy), 32'd0);

      run_round(1'b1, 1'b0, 2'b10, "right");
      run_round(1'b1, 1'b1, 2'b11, "tie_prio");
      run_round(1'b0, 1'b0, 2'b01, "left");

      // Abort during the push window.
      push_countdown();
      clear_stats();
      pulse_start("abort");
      n = 0;
      while (o_speed_round !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach_active", 32'(n < TIMEOUT), 32'd1);
      repeat (3) @(posedge clk);
      #1 i_abort = 1'b1;
      @(posedge clk);
      #1 i_abort = 1'b0;
      @(negedge clk);
      check("abort_round_low", 32'(o_speed_round), 32'd0);
      check("abort_exit_pulse", 32'(o_speed_exit), 32'd1);
      check("abort_winner", 32'(o_winner), 32'd0);
      wait_busy_low("abort");
      repeat (3) @(negedge clk);
      check("abort_exit_pulses", 32'(exit_pulses), 32'd2);
      check("abort_exit_cycles", 32'(exit_cycles), 32'd2);
      check("abort_no_result", 32'(rv_count), 32'd0);
      check("abort_idle", 32'(o_busy), 32'd0);

      // Start held high: one full round, one IDLE cycle, then a fresh round.
      i_speed_right = 1'b1;
      i_speed_tie   = 1'b0;
      exp_win_q.push_back(2'b10);
      push_countdown();
      push_countdown();
      clear_stats();
      @(posedge clk);
      #1 i_start = 1'b1;
      n = 0;
      while (rv_count == 0 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("held_result_timeout", 32'(n < TIMEOUT), 32'd1);
      wait_busy_low("held");
      check("held_exits_first_round", 32'(exit_pulses), 32'd2);
      @(negedge clk);
      check("held_restart_busy", 32'(o_busy), 32'd1);
      check("held_restart_exit", 32'(o_speed_exit), 32'd1);
      check("held_single_result", 32'(rv_count), 32'd1);
      @(posedge clk);
      #1 i_start = 1'b0;

      // Asynchronous reset in the middle of the second round's countdown.
      n = 0;
      while (o_cd_digit !== 4'd2 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_countdown", 32'(n < TIMEOUT), 32'd1);
      saved_exits = exit_pulses;
      #1 rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      exp_cd_q.delete();
      exp_win_q.delete();
      repeat (3) @(negedge clk);
      check("rst_no_exit_pulse", 32'(exit_pulses), 32'(saved_exits));
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_idle", 32'(o_busy), 32'd0);

      run_round(1'b0, 1'b1, 2'b11, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
